// File: rtl/shift_rx_pkg.sv
// Shared types and sizing helpers for the serial frame receiver.
package shift_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam int DATA_W_DEF  = 8;
    localparam int BIT_DIV_DEF = 4;
    localparam int HALF_DIV    = BIT_DIV_DEF / 2;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int half_div(input int bit_div);
        return bit_div / 2;
    endfunction

endpackage

// File: rtl/shift_frame_receiver_bit_timer.sv
// Bit-period counter: counts 0..BIT_DIV-1 and strobes at mid-bit and end-of-bit.
module bit_timer
    import shift_rx_pkg::*;
#(
    parameter int BIT_DIV = BIT_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic half_tick,
    output logic full_tick
);

    localparam int CNT_W = idx_width(BIT_DIV);

    logic [CNT_W-1:0] cnt;

    assign full_tick = (cnt == CNT_W'(BIT_DIV - 1));
    assign half_tick = (cnt == CNT_W'(half_div(BIT_DIV) - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || full_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/shift_frame_receiver.sv
// Serial frame receiver: start bit, LSB-first data, optional even parity, stop bit,
// delivered through a one-entry valid/ready buffer with per-word error flags.
//
// state     | meaning
// ST_IDLE   | line idle, waiting for a low level
// ST_START  | confirming start bit at mid-bit
// ST_DATA   | shifting in DATA_W data bits
// ST_PARITY | capturing the even-parity bit
// ST_STOP   | sampling the stop bit, then completing the frame
module shift_frame_receiver
    import shift_rx_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int BIT_DIV = BIT_DIV_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              serial_in,
    input  logic              parity_en,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun,
    output logic              busy
);

    localparam int IDX_W = idx_width(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    rx_state_e         state;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] shreg;
    logic              par_en_q;
    logic              par_err_q;
    logic              done_q;
    logic              done_ferr;
    logic              half_tick;
    logic              full_tick;
    logic              tmr_restart;

    // Timer is held at zero while idle so the start-bit mid sample lands HALF_DIV edges in.
    assign tmr_restart = !ena || (state == ST_IDLE) || ((state == ST_START) && half_tick);
    assign busy        = (state != ST_IDLE);

    bit_timer #(.BIT_DIV(BIT_DIV)) u_bit_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (tmr_restart),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            shreg     <= '0;
            par_en_q  <= 1'b0;
            par_err_q <= 1'b0;
            done_q    <= 1'b0;
            done_ferr <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!ena) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!serial_in) state <= ST_START;
                    end
                    ST_START: begin
                        if (half_tick) begin
                            if (!serial_in) begin
                                state     <= ST_DATA;
                                idx       <= '0;
                                par_en_q  <= parity_en;
                                par_err_q <= 1'b0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (full_tick) begin
                            shreg <= {serial_in, shreg[DATA_W-1:1]};
                            if (idx == LAST_IDX) begin
                                state <= par_en_q ? ST_PARITY : ST_STOP;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (full_tick) begin
                            par_err_q <= ^{shreg, serial_in};
                            state     <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        // Return to idle without re-arming; a low stop bit is re-examined next cycle.
                        if (full_tick) begin
                            done_q    <= 1'b1;
                            done_ferr <= ~serial_in;
                            state     <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // One-entry output buffer; a slot freed by a same-cycle handshake can take the new word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done_q) begin
                if (!out_valid || out_ready) begin
                    out_data   <= shreg;
                    frame_err  <= done_ferr;
                    parity_err <= par_err_q;
                    out_valid  <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_frame_receiver.sv
// Scoreboard bench for shift_frame_receiver: frames are driven bit-serially and
// delivered words are compared against expectations queued at send time.
module tb_shift_frame_receiver;

    localparam int DATA_W  = 8;
    localparam int BIT_DIV = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ena = 1'b0;
    logic              serial_in = 1'b1;
    logic              parity_en = 1'b0;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              frame_err;
    logic              parity_err;
    logic              overrun;
    logic              busy;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              ferr;
        logic              perr;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   rise_cyc = 0;
    int   vlen = 0;
    int   last_vlen = 0;
    int   ovr_cnt = 0;
    int   words = 0;
    int   snap = 0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    shift_frame_receiver #(.DATA_W(DATA_W), .BIT_DIV(BIT_DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .serial_in  (serial_in),
        .parity_en  (parity_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid && !prev_valid) rise_cyc = cyc;
        if (overrun) ovr_cnt++;
        if (out_valid) begin
            vlen++;
        end else if (prev_valid) begin
            last_vlen = vlen;
            vlen = 0;
        end
        if (rst_n && out_valid && out_ready) begin
            words++;
            chk("sb_pending", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                chk("data", 32'(out_data), 32'(mon_e.data));
                chk("frame_err", 32'(frame_err), 32'(mon_e.ferr));
                chk("parity_err", 32'(parity_err), 32'(mon_e.perr));
            end
        end
        prev_valid = out_valid;
    end

    task automatic drive_bit(input logic b);
        serial_in = b;
        repeat (BIT_DIV) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d, input logic pe,
                              input logic pbit, input logic stop);
        parity_en = pe;
        start_cyc = cyc + 1;
        drive_bit(1'b0);
        for (int i = 0; i < DATA_W; i++) drive_bit(d[i]);
        if (pe) drive_bit(pbit);
        drive_bit(stop);
        serial_in = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input logic ferr, input logic perr);
        exp_t e;
        e.data = d;
        e.ferr = ferr;
        e.perr = perr;
        sb_q.push_back(e);
    endtask

    task automatic chk_outputs_clear(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"}, 32'(out_data), 32'd0);
        chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
        chk({tag, "_perr"}, 32'(parity_err), 32'd0);
        chk({tag, "_ovr"}, 32'(overrun), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_clear("reset");
        rst_n = 1'b1;
        ena = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        push(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        chk("latency_np", 32'(rise_cyc - start_cyc), 32'd39);
        chk("valid_len", 32'(last_vlen), 32'd1);

        push(8'h0F, 1'b0, 1'b1);
        send_frame(8'h0F, 1'b1, 1'b1, 1'b1);
        push(8'h0F, 1'b0, 1'b0);
        send_frame(8'h0F, 1'b1, 1'b0, 1'b1);
        chk("latency_par", 32'(rise_cyc - start_cyc), 32'd43);

        push(8'h3C, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        push(8'h55, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);

        snap = words;
        serial_in = 1'b0;
        @(posedge clk);
        #1;
        serial_in = 1'b1;
        chk("glitch_busy0", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk("glitch_busy1", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk("glitch_busy2", 32'(busy), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("glitch_words", 32'(words - snap), 32'd0);
        chk("glitch_valid", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        snap = ovr_cnt;
        push(8'h11, 1'b0, 1'b0);
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        chk("overrun_cnt", 32'(ovr_cnt - snap), 32'd1);
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'h11);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("drain_valid", 32'(out_valid), 32'd0);

        snap = words;
        out_ready = 1'b0;
        push(8'h99, 1'b0, 1'b0);
        send_frame(8'h99, 1'b0, 1'b0, 1'b1);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        snap = words;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        rst_n = 1'b0;
        serial_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_clear("midreset");
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("midreset_words", 32'(words - snap), 32'd0);

        push(8'h81, 1'b0, 1'b0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);

        repeat (10) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
